// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the system PLL: pulses pll_rst, waits for a stable
// synchronised lock, then releases the PHY; retries on timeout and latches FAIL.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       lock_fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B = (LOCK_STABLE_CYCLES > MAX_RETRIES) ? LOCK_STABLE_CYCLES : MAX_RETRIES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             lock_fail_q, lock_fail_d;
    logic [3:0]       retry_inc;
    logic             lk;

    assign lk = sync2_q;

    always_comb begin
        sync1_d   = pll_locked;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // A lock seen on the last timeout cycle still counts as a lock
                if (lk) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABILIZE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_RESET_PLL;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // A relock request overrides whatever the state decided this cycle
        if (force_relock) begin
            state_d = S_RESET_PLL;
            loss_d  = loss_q;
            retry_d = (state_q == S_FAIL) ? 4'd0 : retry_q;
        end

        if (force_relock || (state_d != state_q)) begin
            cnt_d = '0;
        end

        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
        lock_fail_d = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign ready           = ready_q;
    assign lock_fail       = lock_fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues cycle-tagged expected
// output snapshots, a negedge monitor pops and compares them as cycles arrive.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    int          tag_q[$];
    string       name_q[$];
    logic [15:0] vec_q[$];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES(2)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .pll_locked(pll_locked),
        .force_relock(force_relock),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready(ready),
        .lock_fail(lock_fail),
        .retry_count(retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    function automatic string fmtVec(input logic [15:0] v);
        return $sformatf("pll_rst=%b sys_rst_n=%b ready=%b lock_fail=%b retry=%0d loss=%0d",
                         v[15], v[14], v[13], v[12], v[11:8], v[7:0]);
    endfunction

    task automatic expectAt(input int tag, input string nm, input bit pr, input bit srn,
                            input bit rdy, input bit lf, input int rc, input int llc);
        tag_q.push_back(tag);
        name_q.push_back(nm);
        vec_q.push_back({pr, srn, rdy, lf, 4'(rc), 8'(llc)});
    endtask

    task automatic checkOutput(input string nm, input logic [15:0] exp_v);
        logic [15:0] act_v;
        act_v = {pll_rst, sys_rst_n, ready, lock_fail, retry_count, lock_loss_count};
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s @cycle %0d: got %s, expected %s", nm, cyc, fmtVec(act_v), fmtVec(exp_v));
        end
    endtask

    always @(negedge refclk) begin
        while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
            void'(tag_q.pop_front());
            checkOutput(name_q.pop_front(), vec_q.pop_front());
        end
    end

    task automatic applyStimulus(input logic locked, input logic force_req);
        pll_locked   = locked;
        force_relock = force_req;
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) begin
            @(posedge refclk);
            #1;
        end
    endtask

    initial begin
        int r, l, d, l2, f, h, k, m;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);

        // Clean bring-up: pll_locked first sampled at edge l+1, RUN 2+8 edges later
        waitUntil(3);
        r = cyc;
        expectAt(r,     "reset_state",   1, 0, 0, 0, 0, 0);
        expectAt(r + 3, "rst_pulse_hi",  1, 0, 0, 0, 0, 0);
        expectAt(r + 4, "rst_pulse_lo",  0, 0, 0, 0, 0, 0);
        l = r + 9;
        expectAt(l + 10, "bringup_pre_run", 0, 0, 0, 0, 0, 0);
        expectAt(l + 11, "bringup_run",     0, 1, 1, 0, 0, 0);
        rst_n = 1'b1;
        waitUntil(l);
        applyStimulus(1'b1, 1'b0);

        // Loss of lock in RUN
        d = l + 14;
        expectAt(d + 2, "run_hold",      0, 1, 1, 0, 0, 0);
        expectAt(d + 3, "loss_drop",     1, 0, 0, 0, 0, 1);
        expectAt(d + 6, "loss_pulse_hi", 1, 0, 0, 0, 0, 1);
        expectAt(d + 7, "loss_pulse_lo", 0, 0, 0, 0, 0, 1);
        waitUntil(d);
        applyStimulus(1'b0, 1'b0);
        l2 = d + 8;
        expectAt(l2 + 10, "relock_pre_run", 0, 0, 0, 0, 0, 1);
        expectAt(l2 + 11, "relock_run",     0, 1, 1, 0, 0, 1);
        waitUntil(l2);
        applyStimulus(1'b1, 1'b0);

        // Forced relock from RUN, then a one-cycle lock glitch at stable count 5
        f = l2 + 14;
        expectAt(f + 1,  "force_in_run",   1, 0, 0, 0, 0, 1);
        expectAt(f + 5,  "glitch_wait",    0, 0, 0, 0, 0, 1);
        expectAt(f + 14, "glitch_no_run",  0, 0, 0, 0, 0, 1);
        expectAt(f + 16, "glitch_still",   0, 0, 0, 0, 0, 1);
        expectAt(f + 20, "glitch_pre_run", 0, 0, 0, 0, 0, 1);
        expectAt(f + 21, "glitch_run",     0, 1, 1, 0, 0, 1);
        waitUntil(f);
        applyStimulus(1'b1, 1'b1);
        waitUntil(f + 1);
        applyStimulus(1'b1, 1'b0);
        waitUntil(f + 9);
        applyStimulus(1'b0, 1'b0);
        waitUntil(f + 10);
        applyStimulus(1'b1, 1'b0);

        // force_relock lands on the same edge as the loss of lock; lock then stays low
        h = f + 25;
        expectAt(h,      "coinc_run",      0, 1, 1, 0, 0, 1);
        expectAt(h + 1,  "coinc_force",    1, 0, 0, 0, 0, 1);
        expectAt(h + 2,  "coinc_no_count", 1, 0, 0, 0, 0, 1);
        expectAt(h + 36, "wait1_end",      0, 0, 0, 0, 0, 1);
        expectAt(h + 37, "timeout1",       1, 0, 0, 0, 1, 1);
        expectAt(h + 40, "retry_pulse_hi", 1, 0, 0, 0, 1, 1);
        expectAt(h + 41, "retry_pulse_lo", 0, 0, 0, 0, 1, 1);
        expectAt(h + 72, "wait2_end",      0, 0, 0, 0, 1, 1);
        expectAt(h + 73, "fail_entry",     1, 0, 0, 1, 2, 1);
        expectAt(h + 80, "fail_hold",      1, 0, 0, 1, 2, 1);
        waitUntil(h - 2);
        applyStimulus(1'b0, 1'b0);
        waitUntil(h);
        applyStimulus(1'b0, 1'b1);
        waitUntil(h + 1);
        applyStimulus(1'b0, 1'b0);

        // Leave FAIL, time out once, then lock exactly on the final timeout cycle
        k = h + 82;
        expectAt(k + 1,  "fail_exit",          1, 0, 0, 0, 0, 1);
        expectAt(k + 4,  "exit_pulse_hi",      1, 0, 0, 0, 0, 1);
        expectAt(k + 5,  "exit_pulse_lo",      0, 0, 0, 0, 0, 1);
        expectAt(k + 37, "timeout_again",      1, 0, 0, 0, 1, 1);
        expectAt(k + 41, "wait_again",         0, 0, 0, 0, 1, 1);
        expectAt(k + 73, "lock_beats_timeout", 0, 0, 0, 0, 1, 1);
        expectAt(k + 74, "stabilize_held",     0, 0, 0, 0, 1, 1);
        expectAt(k + 80, "late_pre_run",       0, 0, 0, 0, 1, 1);
        expectAt(k + 81, "late_run",           0, 1, 1, 0, 0, 1);
        waitUntil(k);
        applyStimulus(1'b0, 1'b1);
        waitUntil(k + 1);
        applyStimulus(1'b0, 1'b0);
        waitUntil(k + 70);
        applyStimulus(1'b1, 1'b0);

        // Reset asserted in RUN, then again in STABILIZE
        m = k + 84;
        expectAt(m,      "run_before_reset",  0, 1, 1, 0, 0, 1);
        expectAt(m + 1,  "reset_in_run",      1, 0, 0, 0, 0, 0);
        expectAt(m + 5,  "post_reset_hi",     1, 0, 0, 0, 0, 0);
        expectAt(m + 6,  "post_reset_lo",     0, 0, 0, 0, 0, 0);
        expectAt(m + 10, "stab_before_reset", 0, 0, 0, 0, 0, 0);
        expectAt(m + 11, "reset_in_stab",     1, 0, 0, 0, 0, 0);
        expectAt(m + 15, "restart_hi",        1, 0, 0, 0, 0, 0);
        expectAt(m + 16, "restart_lo",        0, 0, 0, 0, 0, 0);
        expectAt(m + 24, "restart_pre_run",   0, 0, 0, 0, 0, 0);
        expectAt(m + 25, "restart_run",       0, 1, 1, 0, 0, 0);
        waitUntil(m);
        rst_n = 1'b0;
        waitUntil(m + 2);
        rst_n = 1'b1;
        waitUntil(m + 10);
        rst_n = 1'b0;
        waitUntil(m + 12);
        rst_n = 1'b1;

        waitUntil(m + 30);
        for (int i = 0; i < 10 && tag_q.size() > 0; i++) begin
            @(posedge refclk);
            #1;
        end
        while (tag_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: never checked (due cycle %0d, now %0d)", name_q[0], tag_q[0], cyc);
            void'(tag_q.pop_front());
            void'(name_q.pop_front());
            void'(vec_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Control-side counterpart of the 50/100 MHz system PLL: drives the PLL reset input, watches its lock output, and decides when the WiMax PHY pipeline may leave reset.
- Runs on the free-running board reference clock and re-synchronises the PLL lock flag.
- Re-arms the PLL on lock timeout or loss of lock, and flags a hard failure after a bounded number of retries.

Parameters:
- PLL_RST_CYCLES, 16: pll_rst high-pulse width in refclk cycles (>=1).
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK before a retry.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before release (>=1).
- MAX_RETRIES, 3: timeouts tolerated before FAIL (>=1).

Ports:
- refclk  in  1  single clock, 50 MHz board reference.
- rst_n  in  1  synchronous, active-low reset.
- pll_locked  in  1  asynchronous lock flag from the PLL.
- force_relock  in  1  single-cycle request to re-run the sequence; also the only exit from FAIL besides reset.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low reset to the downstream PHY logic.
- ready  out  1  high only in RUN.
- lock_fail  out  1  high only in FAIL.
- retry_count  out  4  timeouts since the last successful lock (saturating at 15).
- lock_loss_count  out  8  loss-of-lock events seen in RUN (saturating at 255).

Behaviour:
- Clock and reset: one clock, refclk. Reset is synchronous and active-low on rst_n; all flops update only on the refclk rising edge.
- Reset values, forced while rst_n=0: state=RESET_PLL, cnt=0, both sync flops=0, pll_rst=1, sys_rst_n=0, ready=0, lock_fail=0, retry_count=0, lock_loss_count=0.
- Synchroniser: pll_locked passes through 2 flops to produce lk. The FSM sees lk only, so lock/unlock latency is 2 cycles.
- Counter: a single cnt register, width $clog2 of the largest parameter +1. It is cleared on every state change.
- Outputs are registered and decoded from the state:
  - pll_rst=1 only in RESET_PLL and FAIL.
  - sys_rst_n=1 only in RUN.
- RESET_PLL: hold pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK (pll_rst=0):
  - lk=1 -> STABILIZE.
  - Otherwise, when cnt reaches LOCK_TIMEOUT_CYCLES-1, retry_count increments.
  - If the new value equals MAX_RETRIES -> FAIL; else -> RESET_PLL.
- STABILIZE:
  - Count consecutive cycles with lk=1.
  - lk=0 -> WAIT_LOCK with a fresh timeout window; retry_count is unchanged.
  - cnt reaches LOCK_STABLE_CYCLES-1 with lk=1 -> RUN, and retry_count clears to 0.
- RUN:
  - sys_rst_n=1, ready=1.
  - lk=0 -> RESET_PLL, lock_loss_count +1. sys_rst_n and ready drop on the same edge the state changes.
- FAIL:
  - pll_rst=1, sys_rst_n=0, lock_fail=1.
  - Held until force_relock or reset.
  - force_relock -> RESET_PLL with retry_count cleared.
- force_relock in any state: next state RESET_PLL, cnt=0. It has priority over every other transition.
  - lock_loss_count is not incremented by force_relock, even in RUN.
  - If force_relock and lk=0 arrive in the same RUN cycle, force_relock wins and there is no increment.
- Simultaneous events:
  - In WAIT_LOCK, timeout and lk=1 on the same cycle -> lock wins (STABILIZE, no retry increment).
  - In STABILIZE, lk=0 and the final stable count on the same cycle -> WAIT_LOCK.
- Mid-operation reset: rst_n=0 from any state restores the reset values on the next edge. There is no partial-state retention and the counters are cleared.
- Saturation: retry_count and lock_loss_count never wrap.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Clean bring-up: release rst_n; raise pll_locked 5 cycles after pll_rst falls, held high.
  - pll_rst is high for 4 cycles after release.
  - sys_rst_n and ready rise exactly 2+8 cycles after pll_locked rises.
  - retry_count=0.
- Timeout then FAIL: keep pll_locked=0.
  - Two 4-cycle pll_rst pulses, each separated by a 32-cycle WAIT_LOCK window.
  - After the 2nd timeout: lock_fail=1, pll_rst stuck at 1, retry_count=2.
  - force_relock -> lock_fail=0, new 4-cycle pulse, retry_count=0.
- Glitchy lock: in STABILIZE, drop pll_locked for 1 cycle at stable count 5.
  - Returns to WAIT_LOCK; RUN is entered only after 8 fresh consecutive locked cycles.
  - sys_rst_n stays 0 throughout.
- Loss of lock in RUN: drop pll_locked.
  - 2 cycles later sys_rst_n=0, ready=0, lock_loss_count=1, pll_rst pulses 4 cycles.
  - Re-lock returns to RUN.
- Reset mid-sequence: assert rst_n=0 during STABILIZE and during RUN.
  - Next edge gives pll_rst=1, sys_rst_n=0, all counts 0.
- Simultaneous events:
  - lk rising on the final WAIT_LOCK timeout cycle -> STABILIZE, retry_count unchanged.
  - force_relock coincident with loss of lock in RUN -> lock_loss_count unchanged.
